// File: rtl/gate_bist.sv
// Self-test sequencer for one 2-input combinational gate: walks all four
// input vectors, samples the gate output after a settle time and scores it.
module gate_bist #(
    parameter logic [3:0] EXPECT = 4'b0111,
    parameter int         SETTLE = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    output logic       a,
    output logic       b,
    input  logic       c,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [2:0] err_count,
    output logic [3:0] fail_vec
);

    // Handshake: start is a level request, accepted on any rising edge where
    // the sequencer is IDLE (including the done cycle) and ignored while busy.
    typedef enum logic {IDLE, RUN} state_t;

    localparam logic [3:0] SETTLE_M1 = 4'(SETTLE - 1);

    state_t     state;
    logic [1:0] vec_idx;
    logic [3:0] settle_cnt;

    logic       miss;
    logic       sample_now;
    logic [2:0] err_next;

    assign miss       = (c != EXPECT[vec_idx]);
    assign sample_now = (settle_cnt == SETTLE_M1);
    assign err_next   = err_count + {2'b00, miss};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            a          <= 1'b0;
            b          <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            pass       <= 1'b0;
            err_count  <= 3'd0;
            fail_vec   <= 4'd0;
            vec_idx    <= 2'd0;
            settle_cnt <= 4'd0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state      <= RUN;
                        busy       <= 1'b1;
                        a          <= 1'b0;
                        b          <= 1'b0;
                        vec_idx    <= 2'd0;
                        settle_cnt <= 4'd0;
                        err_count  <= 3'd0;
                        fail_vec   <= 4'd0;
                        pass       <= 1'b0;
                    end
                end
                RUN: begin
                    if (sample_now) begin
                        err_count <= err_next;
                        if (miss) begin
                            fail_vec[vec_idx] <= 1'b1;
                        end
                        settle_cnt <= 4'd0;
                        if (vec_idx != 2'b11) begin
                            vec_idx <= vec_idx + 2'd1;
                            {a, b}  <= vec_idx + 2'd1;
                        end else begin
                            // Final vector: pass must include this last sample.
                            state   <= IDLE;
                            busy    <= 1'b0;
                            done    <= 1'b1;
                            pass    <= (err_next == 3'd0);
                            vec_idx <= 2'd0;
                            a       <= 1'b0;
                            b       <= 1'b0;
                        end
                    end else begin
                        settle_cnt <= settle_cnt + 4'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
